// File: rtl/encoder6_3_serial_if.sv
// rtl/encoder6_3_serial_if.sv - line-vector in / code-beat out handshake bundle for encoder6_3_serial
interface encoder6_3_serial_if;
    logic       b_valid;
    logic       b_ready;
    logic [5:0] b;
    logic       a_valid;
    logic       a_ready;
    logic [2:0] a;
    logic       a_last;
    logic       a_none;
    logic [2:0] a_cnt;

    modport master (
        output b_valid, b, a_ready,
        input  b_ready, a_valid, a, a_last, a_none, a_cnt
    );

    modport slave (
        input  b_valid, b, a_ready,
        output b_ready, a_valid, a, a_last, a_none, a_cnt
    );
endinterface

// File: rtl/encoder6_3_serial.sv
// rtl/encoder6_3_serial.sv - serial 6-line to 3-bit encoder, one beat per set line
module encoder6_3_serial #(
    parameter logic [2:0] NONE_CODE = 3'd7,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    encoder6_3_serial_if.slave   bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state_q, state_d;
    logic [5:0] pend_q, pend_d;
    logic       b_ready_q, b_ready_d;
    logic       a_valid_q, a_valid_d;
    logic [2:0] a_q, a_d;
    logic       a_last_q, a_last_d;
    logic       a_none_q, a_none_d;
    logic [2:0] a_cnt_q, a_cnt_d;
    logic [5:0] rem;

    function automatic logic [2:0] pick_idx(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        // Later hits overwrite earlier ones, so scan toward the preferred end.
        if (LSB_FIRST) begin
            for (int i = 5; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 0; i < 6; i++)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] popcnt(input logic [5:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++)
            c = c + {2'b00, v[i]};
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        b_ready_d = b_ready_q;
        a_valid_d = a_valid_q;
        a_d       = a_q;
        a_last_d  = a_last_q;
        a_none_d  = a_none_q;
        a_cnt_d   = a_cnt_q;
        rem       = pend_q & ~(6'b000001 << a_q);

        case (state_q)
            IDLE: begin
                if (!b_ready_q) begin
                    b_ready_d = 1'b1;
                end else if (bus.b_valid) begin
                    pend_d    = bus.b;
                    a_cnt_d   = popcnt(bus.b);
                    b_ready_d = 1'b0;
                    a_valid_d = 1'b1;
                    state_d   = EMIT;
                    if (bus.b == 6'b0) begin
                        a_d      = NONE_CODE;
                        a_none_d = 1'b1;
                        a_last_d = 1'b1;
                    end else begin
                        a_d      = pick_idx(bus.b);
                        a_none_d = 1'b0;
                        a_last_d = (popcnt(bus.b) == 3'd1);
                    end
                end
            end
            EMIT: begin
                if (bus.a_ready) begin
                    if (a_last_q) begin
                        a_valid_d = 1'b0;
                        pend_d    = 6'b0;
                        b_ready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        pend_d   = rem;
                        a_d      = pick_idx(rem);
                        a_last_d = (popcnt(rem) == 3'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_q    <= 6'b0;
            b_ready_q <= 1'b0;
            a_valid_q <= 1'b0;
            a_q       <= 3'd0;
            a_last_q  <= 1'b0;
            a_none_q  <= 1'b0;
            a_cnt_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            b_ready_q <= b_ready_d;
            a_valid_q <= a_valid_d;
            a_q       <= a_d;
            a_last_q  <= a_last_d;
            a_none_q  <= a_none_d;
            a_cnt_q   <= a_cnt_d;
        end
    end

    assign bus.b_ready = b_ready_q;
    assign bus.a_valid = a_valid_q;
    assign bus.a       = a_q;
    assign bus.a_last  = a_last_q;
    assign bus.a_none  = a_none_q;
    assign bus.a_cnt   = a_cnt_q;

endmodule

// File: tb/tb_encoder6_3_serial.sv
// tb/tb_encoder6_3_serial.sv - directed-vector bench for encoder6_3_serial
module tb_encoder6_3_serial;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    encoder6_3_serial_if lif ();
    encoder6_3_serial_if mif ();

    encoder6_3_serial #(.NONE_CODE(3'd7), .LSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lif.slave)
    );

    encoder6_3_serial #(.NONE_CODE(3'd7), .LSB_FIRST(1'b0)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (lif.b_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("b_ready_timeout", int'(lif.b_ready === 1'b1), 1);
    endtask

    // codes holds beat j's expected index in bits [3j+:3]
    task automatic run_vec(input logic [5:0] vec, input int n, input logic [17:0] codes,
                           input int cnt, input int none, input bit stall);
        int beat;
        int guard;
        wait_ready();
        lif.b       = vec;
        lif.b_valid = 1'b1;
        lif.a_ready = 1'b1;
        @(negedge clk);
        lif.b_valid = 1'b0;
        lif.b       = ~vec;
        beat  = 0;
        guard = 0;
        while (beat < n && guard < 40) begin
            chk("a_valid", int'(lif.a_valid), 1);
            chk("a", int'(lif.a), int'(codes[3*beat +: 3]));
            chk("a_last", int'(lif.a_last), int'(beat == n - 1));
            chk("a_none", int'(lif.a_none), none);
            chk("a_cnt", int'(lif.a_cnt), cnt);
            chk("b_ready_busy", int'(lif.b_ready), 0);
            lif.a_ready = stall ? ~lif.a_ready : 1'b1;
            if (lif.a_ready) beat++;
            guard++;
            @(negedge clk);
        end
        chk("beats_done", beat, n);
        chk("a_valid_end", int'(lif.a_valid), 0);
        chk("b_ready_end", int'(lif.b_ready), 1);
        lif.a_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        lif.b_valid = 1'b0; lif.b = 6'b0; lif.a_ready = 1'b1;
        mif.b_valid = 1'b0; mif.b = 6'b0; mif.a_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_b_ready", int'(lif.b_ready), 0);
        chk("rst_a_valid", int'(lif.a_valid), 0);
        chk("rst_a", int'(lif.a), 0);
        chk("rst_a_cnt", int'(lif.a_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_b_ready", int'(lif.b_ready), 1);
        chk("rel_a_valid", int'(lif.a_valid), 0);

        for (int i = 0; i < 6; i++)
            run_vec(6'b000001 << i, 1, 18'(i), 1, 0, 1'b0);

        run_vec(6'b101010, 3, 18'o000531, 3, 0, 1'b0);
        run_vec(6'b000000, 1, 18'o000007, 0, 1, 1'b0);
        run_vec(6'b111111, 6, 18'o543210, 6, 0, 1'b0);
        run_vec(6'b010011, 3, 18'o000410, 3, 0, 1'b1);

        // last beat accepted while b_valid already high: capture waits a cycle
        wait_ready();
        lif.b = 6'b000001; lif.b_valid = 1'b1;
        @(negedge clk);
        chk("ovl_beat_a", int'(lif.a), 0);
        chk("ovl_beat_last", int'(lif.a_last), 1);
        lif.b = 6'b000010;
        @(negedge clk);
        chk("ovl_gap_valid", int'(lif.a_valid), 0);
        chk("ovl_gap_ready", int'(lif.b_ready), 1);
        @(negedge clk);
        lif.b_valid = 1'b0;
        chk("ovl_next_valid", int'(lif.a_valid), 1);
        chk("ovl_next_a", int'(lif.a), 1);
        @(negedge clk);
        chk("ovl_next_done", int'(lif.a_valid), 0);

        // reset after the first beat of 111000 is accepted
        wait_ready();
        lif.b = 6'b111000; lif.b_valid = 1'b1;
        @(negedge clk);
        lif.b_valid = 1'b0;
        chk("rmid_a0", int'(lif.a), 3);
        @(negedge clk);
        chk("rmid_a1", int'(lif.a), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_valid_drop", int'(lif.a_valid), 0);
        chk("rmid_b_ready", int'(lif.b_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_rel_ready", int'(lif.b_ready), 1);
        run_vec(6'b000100, 1, 18'o000002, 1, 0, 1'b0);

        // highest-index-first variant
        mif.b = 6'b101010; mif.b_valid = 1'b1;
        @(negedge clk);
        mif.b_valid = 1'b0;
        chk("msb_a0", int'(mif.a), 5);
        chk("msb_last0", int'(mif.a_last), 0);
        chk("msb_cnt", int'(mif.a_cnt), 3);
        @(negedge clk);
        chk("msb_a1", int'(mif.a), 3);
        @(negedge clk);
        chk("msb_a2", int'(mif.a), 1);
        chk("msb_last2", int'(mif.a_last), 1);
        @(negedge clk);
        chk("msb_done", int'(mif.a_valid), 0);
        chk("msb_ready", int'(mif.b_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
